// File: rtl/mem_response_router.sv
// Routes read responses from memory targets back to their initiators, preserving each
// initiator's request order across targets with per-target and per-initiator tracking FIFOs.
module mem_response_router #(
   parameter int unsigned SLAVE_PORTS  = 1,
   parameter int unsigned MASTER_PORTS = 1,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned TRACK_DEPTH  = 4,
   localparam int unsigned SW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1,
   localparam int unsigned MW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     issue_valid,
   output logic                                     issue_ready,
   input  logic [SW-1:0]                            issue_slave,
   input  logic [MW-1:0]                            issue_master,
   input  logic [MASTER_PORTS-1:0]                  resp_valid,
   output logic [MASTER_PORTS-1:0]                  resp_ready,
   input  logic [MASTER_PORTS-1:0][DATA_WIDTH-1:0]  resp_data,
   output logic [SLAVE_PORTS-1:0]                   out_valid,
   input  logic [SLAVE_PORTS-1:0]                   out_ready,
   output logic [SLAVE_PORTS-1:0][DATA_WIDTH-1:0]   out_data,
   output logic                                     idle
);

   localparam int unsigned PW = $clog2(TRACK_DEPTH);
   localparam int unsigned CW = PW + 1;

   // MQ: initiator indices per target; SQ: target indices per initiator
   logic [SW-1:0] mq_mem   [MASTER_PORTS][TRACK_DEPTH];
   logic [PW-1:0] mq_rd_q  [MASTER_PORTS];
   logic [PW-1:0] mq_wr_q  [MASTER_PORTS];
   logic [CW-1:0] mq_cnt_q [MASTER_PORTS];
   logic [SW-1:0] mq_head  [MASTER_PORTS];
   logic [MASTER_PORTS-1:0] mq_push;

   logic [MW-1:0] sq_mem   [SLAVE_PORTS][TRACK_DEPTH];
   logic [PW-1:0] sq_rd_q  [SLAVE_PORTS];
   logic [PW-1:0] sq_wr_q  [SLAVE_PORTS];
   logic [CW-1:0] sq_cnt_q [SLAVE_PORTS];
   logic [MW-1:0] sq_head  [SLAVE_PORTS];
   logic [SLAVE_PORTS-1:0] sq_push;
   logic [SLAVE_PORTS-1:0] sq_pop;

   logic [MASTER_PORTS-1:0]                resp_accept;
   logic [SLAVE_PORTS-1:0][DATA_WIDTH-1:0] load_data;
   logic mq_hit, mq_full, sq_hit, sq_full, issue_fire;

   always_comb begin
      for (int m = 0; m < MASTER_PORTS; m++) mq_head[m] = mq_mem[m][mq_rd_q[m]];
      for (int s = 0; s < SLAVE_PORTS; s++)  sq_head[s] = sq_mem[s][sq_rd_q[s]];
   end

   // Issue side: full checks use registered counts, so a same-cycle pop never frees space
   always_comb begin
      mq_hit  = 1'b0;
      mq_full = 1'b0;
      sq_hit  = 1'b0;
      sq_full = 1'b0;
      for (int m = 0; m < MASTER_PORTS; m++) begin
         if (issue_master == MW'(m)) begin
            mq_hit  = 1'b1;
            mq_full = (mq_cnt_q[m] == CW'(TRACK_DEPTH));
         end
      end
      for (int s = 0; s < SLAVE_PORTS; s++) begin
         if (issue_slave == SW'(s)) begin
            sq_hit  = 1'b1;
            sq_full = (sq_cnt_q[s] == CW'(TRACK_DEPTH));
         end
      end
      issue_ready = mq_hit && sq_hit && !mq_full && !sq_full;
      issue_fire  = issue_valid && issue_ready;
      for (int m = 0; m < MASTER_PORTS; m++) mq_push[m] = issue_fire && (issue_master == MW'(m));
      for (int s = 0; s < SLAVE_PORTS; s++)  sq_push[s] = issue_fire && (issue_slave == SW'(s));
   end

   // A target matches only when it heads its initiator's order queue, so no arbitration
   always_comb begin
      for (int m = 0; m < MASTER_PORTS; m++) begin
         resp_ready[m] = 1'b0;
         for (int s = 0; s < SLAVE_PORTS; s++) begin
            if (mq_cnt_q[m] != '0 && mq_head[m] == SW'(s) && sq_cnt_q[s] != '0 &&
                sq_head[s] == MW'(m) && (!out_valid[s] || out_ready[s])) begin
               resp_ready[m] = 1'b1;
            end
         end
      end
      resp_accept = resp_valid & resp_ready;
      for (int s = 0; s < SLAVE_PORTS; s++) begin
         sq_pop[s]    = 1'b0;
         load_data[s] = '0;
         for (int m = 0; m < MASTER_PORTS; m++) begin
            if (resp_accept[m] && mq_head[m] == SW'(s)) begin
               sq_pop[s]    = 1'b1;
               load_data[s] = resp_data[m];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int m = 0; m < MASTER_PORTS; m++) begin
         if (mq_push[m]) mq_mem[m][mq_wr_q[m]] <= issue_slave;
      end
      for (int s = 0; s < SLAVE_PORTS; s++) begin
         if (sq_push[s]) sq_mem[s][sq_wr_q[s]] <= issue_master;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int m = 0; m < MASTER_PORTS; m++) begin
            mq_rd_q[m]  <= '0;
            mq_wr_q[m]  <= '0;
            mq_cnt_q[m] <= '0;
         end
         for (int s = 0; s < SLAVE_PORTS; s++) begin
            sq_rd_q[s]  <= '0;
            sq_wr_q[s]  <= '0;
            sq_cnt_q[s] <= '0;
         end
         out_valid <= '0;
         out_data  <= '0;
      end else begin
         for (int m = 0; m < MASTER_PORTS; m++) begin
            if (mq_push[m])     mq_wr_q[m] <= mq_wr_q[m] + 1'b1;
            if (resp_accept[m]) mq_rd_q[m] <= mq_rd_q[m] + 1'b1;
            if (mq_push[m] && !resp_accept[m])      mq_cnt_q[m] <= mq_cnt_q[m] + 1'b1;
            else if (!mq_push[m] && resp_accept[m]) mq_cnt_q[m] <= mq_cnt_q[m] - 1'b1;
         end
         for (int s = 0; s < SLAVE_PORTS; s++) begin
            if (sq_push[s]) sq_wr_q[s] <= sq_wr_q[s] + 1'b1;
            if (sq_pop[s])  sq_rd_q[s] <= sq_rd_q[s] + 1'b1;
            if (sq_push[s] && !sq_pop[s])      sq_cnt_q[s] <= sq_cnt_q[s] + 1'b1;
            else if (!sq_push[s] && sq_pop[s]) sq_cnt_q[s] <= sq_cnt_q[s] - 1'b1;
            if (sq_pop[s]) begin
               out_valid[s] <= 1'b1;
               out_data[s]  <= load_data[s];
            end else if (out_ready[s]) begin
               out_valid[s] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      idle = (out_valid == '0);
      for (int m = 0; m < MASTER_PORTS; m++) begin
         if (mq_cnt_q[m] != '0) idle = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_response_router.sv
// Directed self-checking bench for mem_response_router with two initiators and two targets.
module tb_mem_response_router;

   logic             clk = 1'b0;
   logic             rst;
   logic             issue_valid;
   logic             issue_ready;
   logic [0:0]       issue_slave;
   logic [0:0]       issue_master;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_ready;
   logic [1:0][31:0] resp_data;
   logic [1:0]       out_valid;
   logic [1:0]       out_ready;
   logic [1:0][31:0] out_data;
   logic             idle;

   int n_checks = 0;
   int n_fail   = 0;

   mem_response_router #(
      .SLAVE_PORTS (2),
      .MASTER_PORTS(2),
      .DATA_WIDTH  (32),
      .TRACK_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_slave (issue_slave),
      .issue_master(issue_master),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .idle        (idle)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic s, input logic m);
      issue_valid  = 1'b1;
      issue_slave  = s;
      issue_master = m;
      #1;
      check_eq("issue_ready_on_issue", 64'(issue_ready), 64'(1));
      tick();
      issue_valid  = 1'b0;
      issue_slave  = 1'b0;
      issue_master = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      issue_valid  = 1'b0;
      issue_slave  = 1'b0;
      issue_master = 1'b0;
      resp_valid   = 2'b00;
      resp_data    = '0;
      out_ready    = 2'b00;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check_eq("rst_idle", 64'(idle), 64'(1));
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_out_data", 64'(out_data), 64'(0));
      check_eq("rst_resp_ready", 64'(resp_ready), 64'(0));
      check_eq("rst_issue_ready", 64'(issue_ready), 64'(1));

      // Single path
      issue(1'b0, 1'b1);
      check_eq("single_busy", 64'(idle), 64'(0));
      tick();
      resp_valid   = 2'b10;
      resp_data[1] = 32'hCAFE0001;
      #1;
      check_eq("single_resp_ready", 64'(resp_ready), 64'(2'b10));
      tick();
      resp_valid = 2'b00;
      check_eq("single_out_valid", 64'(out_valid), 64'(2'b01));
      check_eq("single_out_data", 64'(out_data[0]), 64'(32'hCAFE0001));
      check_eq("single_not_idle", 64'(idle), 64'(0));
      out_ready = 2'b01;
      tick();
      out_ready = 2'b00;
      check_eq("single_drained", 64'(out_valid), 64'(0));
      check_eq("single_idle", 64'(idle), 64'(1));

      // Cross-target ordering: m1 answers first but must wait behind m0
      issue(1'b0, 1'b0);
      issue(1'b0, 1'b1);
      resp_valid   = 2'b10;
      resp_data[1] = 32'h0000000B;
      #1;
      check_eq("order_m1_stall", 64'(resp_ready), 64'(2'b01));
      tick();
      check_eq("order_m1_still_stall", 64'(resp_ready[1]), 64'(0));
      check_eq("order_nothing_out", 64'(out_valid), 64'(0));
      resp_valid   = 2'b11;
      resp_data[0] = 32'h0000000A;
      tick();
      resp_valid = 2'b10;
      check_eq("order_first_valid", 64'(out_valid), 64'(2'b01));
      check_eq("order_first_data", 64'(out_data[0]), 64'(32'hA));
      check_eq("order_m1_blocked_by_out", 64'(resp_ready), 64'(2'b00));
      out_ready = 2'b01;
      #1;
      check_eq("order_m1_ready", 64'(resp_ready), 64'(2'b10));
      tick();
      resp_valid = 2'b00;
      check_eq("order_second_valid", 64'(out_valid), 64'(2'b01));
      check_eq("order_second_data", 64'(out_data[0]), 64'(32'hB));
      tick();
      out_ready = 2'b00;
      check_eq("order_idle", 64'(idle), 64'(1));

      // Parallel disjoint pairs
      issue(1'b0, 1'b0);
      issue(1'b1, 1'b1);
      resp_valid   = 2'b11;
      resp_data[0] = 32'h11110000;
      resp_data[1] = 32'h22221111;
      #1;
      check_eq("par_resp_ready", 64'(resp_ready), 64'(2'b11));
      tick();
      resp_valid = 2'b00;
      check_eq("par_out_valid", 64'(out_valid), 64'(2'b11));
      check_eq("par_out_data0", 64'(out_data[0]), 64'(32'h11110000));
      check_eq("par_out_data1", 64'(out_data[1]), 64'(32'h22221111));
      out_ready = 2'b11;
      tick();
      out_ready = 2'b00;
      check_eq("par_idle", 64'(idle), 64'(1));

      // Full tracking and output backpressure
      for (int i = 0; i < 4; i++) issue(1'b0, 1'b0);
      #1;
      check_eq("full_s0m0", 64'(issue_ready), 64'(0));
      issue_slave  = 1'b1;
      issue_master = 1'b1;
      #1;
      check_eq("full_s1m1_open", 64'(issue_ready), 64'(1));
      issue_master = 1'b0;
      #1;
      check_eq("full_s1m0_mq_full", 64'(issue_ready), 64'(0));
      issue_slave  = 1'b0;
      issue_master = 1'b1;
      #1;
      check_eq("full_s0m1_sq_full", 64'(issue_ready), 64'(0));
      issue_master = 1'b0;
      resp_valid   = 2'b01;
      resp_data[0] = 32'hD0;
      #1;
      check_eq("full_resp_ready", 64'(resp_ready), 64'(2'b01));
      check_eq("full_blocks_despite_pop", 64'(issue_ready), 64'(0));
      tick();
      resp_data[0] = 32'hD1;
      check_eq("bp_out_data", 64'(out_data[0]), 64'(32'hD0));
      check_eq("bp_stall", 64'(resp_ready), 64'(2'b00));
      check_eq("bp_space_freed", 64'(issue_ready), 64'(1));
      tick();
      check_eq("bp_still_stall", 64'(resp_ready), 64'(2'b00));
      check_eq("bp_data_held", 64'(out_data[0]), 64'(32'hD0));
      out_ready = 2'b01;
      #1;
      check_eq("bp_release", 64'(resp_ready), 64'(2'b01));
      tick();
      check_eq("bp_reload_valid", 64'(out_valid), 64'(2'b01));
      check_eq("bp_reload_d1", 64'(out_data[0]), 64'(32'hD1));
      resp_data[0] = 32'hD2;
      tick();
      check_eq("bp_reload_d2", 64'(out_data[0]), 64'(32'hD2));
      resp_data[0] = 32'hD3;
      tick();
      check_eq("bp_reload_d3", 64'(out_data[0]), 64'(32'hD3));
      #1;
      check_eq("bp_mq_drained", 64'(resp_ready), 64'(2'b00));
      resp_valid = 2'b00;
      tick();
      out_ready = 2'b00;
      check_eq("bp_idle", 64'(idle), 64'(1));

      // Unsolicited response never routes
      resp_valid   = 2'b10;
      resp_data[1] = 32'hBAD00001;
      #1;
      check_eq("unsol_resp_ready", 64'(resp_ready), 64'(2'b00));
      tick();
      check_eq("unsol_no_out", 64'(out_valid), 64'(0));
      resp_valid = 2'b00;

      // Reset with three reads outstanding and one output pending
      issue(1'b0, 1'b0);
      issue(1'b1, 1'b1);
      issue(1'b0, 1'b1);
      issue(1'b1, 1'b0);
      resp_valid   = 2'b01;
      resp_data[0] = 32'hE0;
      tick();
      resp_valid = 2'b00;
      check_eq("pre_rst_out_valid", 64'(out_valid), 64'(2'b01));
      check_eq("pre_rst_busy", 64'(idle), 64'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_idle", 64'(idle), 64'(1));
      check_eq("mid_rst_out_valid", 64'(out_valid), 64'(0));
      resp_valid = 2'b10;
      #1;
      check_eq("mid_rst_unsol", 64'(resp_ready), 64'(2'b00));
      tick();
      resp_valid = 2'b00;
      check_eq("mid_rst_no_out", 64'(out_valid), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_response_router.md
# mem_response_router

Return-path companion to the memory request crossbar. It routes read responses from MASTER_PORTS memory targets back to the SLAVE_PORTS initiators that issued them. Per-target and per-initiator tracking FIFOs preserve each initiator's request order, even when its reads were spread over several targets. It sits beside the crossbar and records every read request the crossbar hands to a target.

## Interface
- SLAVE_PORTS, 1, number of initiators (response outputs); must be > 0
- MASTER_PORTS, 1, number of targets (response inputs); must be > 0
- DATA_WIDTH, 32, response data width
- TRACK_DEPTH, 4, entries per tracking FIFO; power of 2, >= 2
- SW = max(1, $clog2(SLAVE_PORTS)), MW = max(1, $clog2(MASTER_PORTS)) (derived)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  a read request was handed to a target this cycle
- issue_ready  out  1  tracking space available; crossbar must not complete a read to a target unless high
- issue_slave  in  SW  originating initiator index
- issue_master  in  MW  target index
- resp_valid  in  MASTER_PORTS  per-target response valid
- resp_ready  out  MASTER_PORTS  per-target response accept
- resp_data  in  MASTER_PORTS x DATA_WIDTH  per-target response data
- out_valid  out  SLAVE_PORTS  per-initiator response valid (registered)
- out_ready  in  SLAVE_PORTS  per-initiator accept
- out_data  out  SLAVE_PORTS x DATA_WIDTH  per-initiator response data (registered)
- idle  out  1  no outstanding reads and no out_valid set

## Operation
- Tracking state:
  - MQ[m] per target: FIFO of initiator indices, in issue order to target m.
  - SQ[s] per initiator: FIFO of target indices, in issue order from initiator s.
  - Each FIFO has TRACK_DEPTH entries; its count is $clog2(TRACK_DEPTH)+1 bits wide.
- Issue:
  - issue_ready = !full(MQ[issue_master]) && !full(SQ[issue_slave]); combinational on issue_* and registered counts.
  - On issue_valid && issue_ready, push issue_slave into MQ[issue_master] and issue_master into SQ[issue_slave].
  - issue_valid with issue_ready low is dropped. Upstream must not do this; the bench flags it.
- Response match: for target m with s = head(MQ[m]):
  - resp_ready[m] = !empty(MQ[m]) && !empty(SQ[s]) && head(SQ[s]) == m && (!out_valid[s] || out_ready[s]).
  - At most one target can match a given initiator's SQ head, so there is no arbitration and disjoint target/initiator pairs proceed in parallel.
- Response accept (resp_valid[m] && resp_ready[m]):
  - Pop MQ[m] and SQ[s].
  - out_data[s] <= resp_data[m]; out_valid[s] <= 1.
- Output: out_valid[s] clears on out_ready[s] unless reloaded the same cycle. Reload-while-draining is allowed, giving one response per cycle per initiator.
- Target with MQ empty: resp_ready low. An unsolicited response stalls and is never routed.
- idle = all MQ empty && out_valid == 0.

## Timing
- Reset values: out_valid 0, out_data 0, all FIFOs empty, idle 1, resp_ready 0.
- issue_ready is combinational. It is 1 after reset whenever the addressed FIFOs are not full.
- Latency: response handshake in cycle N produces out_valid in cycle N+1. Full throughput is 1 response/cycle per initiator.
- Issue is visible to matching from the next cycle. A response cannot be accepted in the same cycle as its own issue.
- Push and pop on the same FIFO in one cycle: the count is unchanged and both take effect. issue_ready uses the pre-pop count, so a full FIFO blocks issue even when a pop happens that cycle.
- Pointers wrap modulo TRACK_DEPTH. Full = count == TRACK_DEPTH.
- rst asserted mid-operation: all tracking is discarded and out_valid clears the next cycle. Outstanding responses still held by targets are then unsolicited and stall. Upstream must reset them together.

## Test plan
- Single path: S=2, M=2. Issue (s0,m1); drive resp_data[1]=0xCAFE0001 two cycles later → resp_ready[1]=1, then next cycle out_valid[0]=1 with out_data[0]=0xCAFE0001; idle returns to 1 after out_ready[0].
- Cross-target ordering: issue (s0,m0) then (s0,m1). Respond m1 first (0xB), then m0 (0xA) → m1 stalls (resp_ready[1]=0) until m0 is accepted; out_data[0] sequence is 0xA, 0xB.
- Parallel: issue (s0,m0) and (s1,m1). Both targets respond in the same cycle → both accepted that cycle; out_valid=2'b11 the next cycle.
- Full/backpressure: TRACK_DEPTH=4. Issue 4 reads (s0,m0) → issue_ready=0 for m0/s0 while issue_ready stays 1 for (s1,m1). Hold out_ready[0]=0 → after one response, resp_ready[0]=0 until out_ready[0] rises.
- Unsolicited and reset: with no issues, assert resp_valid[1] → resp_ready[1] stays 0. Assert rst with 3 reads outstanding → next cycle idle=1 and out_valid=0.
